// File: rtl/spis.sv
// spis: SPI target (mode 0, MSB first, 8-bit frames) on the IO bus, with rx and tx byte FIFOs.
// Latency: SPI pin change to action is 3 clk; CPU accesses are zero wait state (ack = stb).
// Backpressure: none on the bus. A full rx FIFO drops the byte and sets overrun. An empty tx FIFO sends fill and sets underrun.
//
// Ports:
//   clk, rst_n                          system clock, async active-low reset
//   stb, we, addr, data_in -> data_out  IO bus; addr 0 = data, addr 1 = ctrl/status
//   ack                                 access acknowledge (combinational copy of stb)
//   sclk, cs_n, mosi                    async SPI pins from the external master
//   miso, miso_oe                       serial data out and its pad enable

module spis_fifo #(
  parameter int SLOTS = 16,
  parameter int CW    = $clog2(SLOTS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [7:0]    push_dat_i,
  input  logic          pop_i,
  output logic [7:0]    head_dat_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam int AW = $clog2(SLOTS);

  logic [7:0]    mem_q [SLOTS];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(SLOTS));
  assign pop_ok     = pop_i & ~empty_o;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign push_ok    = push_i & (~full_o | pop_ok);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage needs no reset: the count alone says which slots are valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

module spis #(
  parameter int fifo_slots = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe
);
  localparam int CW = $clog2(fifo_slots) + 1;

  // Pin synchronisers. Bit 1 is the synced value. Bit 2 is the previous synced value, used for edge detection.
  logic [2:0] sclk_q, cs_n_q;
  logic [1:0] mosi_q;

  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       load_nxt_q, load_nxt_d;
  logic       overrun_q, overrun_d;
  logic       underrun_q, underrun_d;
  logic [7:0] fill_q, fill_d;

  logic sel, sel_rise, sel_fall, sclk_rise, sclk_fall, mosi_s;
  logic rd0, wr0, rd1, wr1;
  logic rx_push, tx_pop, tx_load;
  logic overrun_set, underrun_set;

  logic [7:0]    rx_head, tx_head;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic          rx_empty, rx_full, tx_empty, tx_full;

  logic unused_data;
  assign unused_data = ^{data_in[23:17], data_in[15:10]};

  assign sel       = ~cs_n_q[1];
  assign sel_rise  = ~cs_n_q[1] &  cs_n_q[2];
  assign sel_fall  =  cs_n_q[1] & ~cs_n_q[2];
  assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
  assign mosi_s    = mosi_q[1];

  assign rd0 = stb & ~we & ~addr;
  assign wr0 = stb &  we & ~addr;
  assign rd1 = stb & ~we &  addr;
  assign wr1 = stb &  we &  addr;

  assign ack     = stb;
  assign miso_oe = sel;
  assign miso    = sel & tx_sh_q[7];

  spis_fifo #(.SLOTS(fifo_slots), .CW(CW)) u_rx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (wr1 & data_in[8]),
    .push_i     (rx_push),
    .push_dat_i ({rx_sh_q[6:0], mosi_s}),
    .pop_i      (rd0),
    .head_dat_o (rx_head),
    .count_o    (rx_cnt),
    .empty_o    (rx_empty),
    .full_o     (rx_full)
  );

  spis_fifo #(.SLOTS(fifo_slots), .CW(CW)) u_tx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (wr1 & data_in[9]),
    .push_i     (wr0),
    .push_dat_i (data_in[7:0]),
    .pop_i      (tx_pop),
    .head_dat_o (tx_head),
    .count_o    (tx_cnt),
    .empty_o    (tx_empty),
    .full_o     (tx_full)
  );

  // Serial engine. Frame edges take priority over sclk edges seen in the same cycle.
  always_comb begin
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    bitcnt_d   = bitcnt_q;
    load_nxt_d = load_nxt_q;
    rx_push    = 1'b0;
    tx_load    = 1'b0;
    if (sel_fall) begin
      // Abort: the partial rx byte is dropped. Whatever tx_sh held stays consumed.
      rx_sh_d    = '0;
      bitcnt_d   = '0;
      load_nxt_d = 1'b0;
    end else if (sel_rise) begin
      rx_sh_d    = '0;
      bitcnt_d   = '0;
      load_nxt_d = 1'b0;
      tx_load    = 1'b1;
    end else if (sel) begin
      if (sclk_rise) begin
        rx_sh_d = {rx_sh_q[6:0], mosi_s};
        if (bitcnt_q == 3'd7) begin
          rx_push    = 1'b1;
          bitcnt_d   = '0;
          load_nxt_d = 1'b1;
        end else begin
          bitcnt_d = bitcnt_q + 3'd1;
        end
      end else if (sclk_fall) begin
        if (load_nxt_q) begin
          tx_load    = 1'b1;
          load_nxt_d = 1'b0;
        end else begin
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
      end
    end
    if (tx_load) tx_sh_d = tx_empty ? fill_q : tx_head;
  end

  assign tx_pop       = tx_load & ~tx_empty;
  assign underrun_set = tx_load &  tx_empty;
  assign overrun_set  = rx_push & rx_full & ~(rd0 & ~rx_empty);

  // Sticky flags: a set from the SPI side beats a CPU clear in the same cycle.
  always_comb begin
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    fill_d     = fill_q;
    if (wr1 && data_in[2]) overrun_d  = 1'b0;
    if (wr1 && data_in[3]) underrun_d = 1'b0;
    if (overrun_set)       overrun_d  = 1'b1;
    if (underrun_set)      underrun_d = 1'b1;
    if (wr1 && data_in[16]) fill_d = data_in[31:24];
  end

  always_comb begin
    data_out = '0;
    if (rd0) begin
      data_out = {24'b0, rx_empty ? 8'h00 : rx_head};
    end else if (rd1) begin
      data_out = {fill_q, 8'(tx_cnt), 8'(rx_cnt), 2'b00, tx_empty, sel,
                  underrun_q, overrun_q, ~tx_full, ~rx_empty};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q     <= 3'b000;
      cs_n_q     <= 3'b111;
      mosi_q     <= 2'b00;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      bitcnt_q   <= '0;
      load_nxt_q <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      fill_q     <= 8'hFF;
    end else begin
      sclk_q     <= {sclk_q[1:0], sclk};
      cs_n_q     <= {cs_n_q[1:0], cs_n};
      mosi_q     <= {mosi_q[0], mosi};
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      bitcnt_q   <= bitcnt_d;
      load_nxt_q <= load_nxt_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      fill_q     <= fill_d;
    end
  end
endmodule

// File: tb/tb_spis.sv
// tb_spis: directed bench for the spis SPI target.
// Drives the IO bus on negedges and runs a mode-0 SPI master at sclk = clk/10.
// Expected values are hand-computed from the register map.

module tb_spis;
  logic        clk = 1'b0;
  logic        rst_n, stb, we, addr;
  logic [31:0] data_in, data_out;
  logic        ack, sclk, cs_n, mosi, miso, miso_oe;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_out [32];
  logic [7:0] m_in  [32];

  typedef struct {
    bit          we;
    bit          addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [12];

  always #25 clk = ~clk;

  spis #(.fifo_slots(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus access: stb is held for exactly one clk, and data_out is sampled mid-cycle.
  task automatic bus(input bit w, input bit a, input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    stb = 1'b1; we = w; addr = a; data_in = wd;
    #1;
    rd = data_out;
    check("ack", {31'b0, ack}, 32'd1);
    @(negedge clk);
    stb = 1'b0; we = 1'b0; addr = 1'b0; data_in = '0;
  endtask

  task automatic wr(input bit a, input logic [31:0] wd);
    logic [31:0] dummy;
    bus(1'b1, a, wd, dummy);
  endtask

  task automatic rd(input bit a, input logic [31:0] exp, input string nm);
    logic [31:0] v;
    bus(1'b0, a, '0, v);
    check(nm, v, exp);
  endtask

  // Mode-0 master: mosi is set while sclk is low, and miso is sampled at the rise.
  // After the last rise, cs_n goes high before sclk falls, so the target never sees a trailing fall.
  task automatic spi_xfer(input int nbits);
    for (int i = 0; i < 32; i++) m_in[i] = 8'h00;
    cs_n = 1'b0;
    wait_clk(5);
    check("miso_oe_sel", {31'b0, miso_oe}, 32'd1);
    for (int b = 0; b < nbits; b++) begin
      mosi = m_out[b / 8][7 - (b % 8)];
      wait_clk(5);
      sclk = 1'b1;
      m_in[b / 8][7 - (b % 8)] = miso;
      wait_clk(5);
      if (b != nbits - 1) sclk = 1'b0;
    end
    cs_n = 1'b1;
    wait_clk(4);
    sclk = 1'b0;
    mosi = 1'b0;
    wait_clk(4);
  endtask

  initial begin
    vt[0]  = '{we: 1'b0, addr: 1'b1, wd: 32'h0,        exp: 32'hFF000022}; // reset: tx empty and not full, fill FF
    vt[1]  = '{we: 1'b0, addr: 1'b0, wd: 32'h0,        exp: 32'h00000000}; // empty rx reads 0
    vt[2]  = '{we: 1'b1, addr: 1'b1, wd: 32'h5A010000, exp: 32'h0};
    vt[3]  = '{we: 1'b0, addr: 1'b1, wd: 32'h0,        exp: 32'h5A000022};
    vt[4]  = '{we: 1'b1, addr: 1'b1, wd: 32'h12000000, exp: 32'h0};        // bit16=0: fill kept
    vt[5]  = '{we: 1'b0, addr: 1'b1, wd: 32'h0,        exp: 32'h5A000022};
    vt[6]  = '{we: 1'b1, addr: 1'b1, wd: 32'hFF010000, exp: 32'h0};
    vt[7]  = '{we: 1'b0, addr: 1'b1, wd: 32'h0,        exp: 32'hFF000022};
    vt[8]  = '{we: 1'b1, addr: 1'b0, wd: 32'h000000A5, exp: 32'h0};
    vt[9]  = '{we: 1'b0, addr: 1'b1, wd: 32'h0,        exp: 32'hFF010002};
    vt[10] = '{we: 1'b1, addr: 1'b0, wd: 32'h0000003C, exp: 32'h0};
    vt[11] = '{we: 1'b0, addr: 1'b1, wd: 32'h0,        exp: 32'hFF020002};

    rst_n = 1'b0; stb = 1'b0; we = 1'b0; addr = 1'b0; data_in = '0;
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    for (int i = 0; i < 32; i++) m_out[i] = 8'h00;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    #1;
    check("rst_miso_oe", {31'b0, miso_oe}, 32'd0);
    check("rst_miso", {31'b0, miso}, 32'd0);
    check("idle_data_out", data_out, 32'd0);
    check("idle_ack", {31'b0, ack}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      if (vt[i].we) wr(vt[i].addr, vt[i].wd);
      else          rd(vt[i].addr, vt[i].exp, $sformatf("vec%0d", i));
    end

    // Two-byte frame: the master receives A5 then 3C, and rx gets 11 then 22.
    m_out[0] = 8'h11; m_out[1] = 8'h22;
    spi_xfer(16);
    check("t2_miso_b0", {24'b0, m_in[0]}, 32'hA5);
    check("t2_miso_b1", {24'b0, m_in[1]}, 32'h3C);
    rd(1'b1, 32'hFF000223, "t2_status");
    rd(1'b0, 32'h11, "t2_rx0");
    rd(1'b0, 32'h22, "t2_rx1");
    rd(1'b0, 32'h00, "t2_rx_empty");
    rd(1'b1, 32'hFF000022, "t2_status_after");

    // Underrun: the tx FIFO is empty, so the target sends fill = 5A.
    wr(1'b1, 32'h5A010000);
    m_out[0] = 8'hC3;
    spi_xfer(8);
    check("t3_fill_sent", {24'b0, m_in[0]}, 32'h5A);
    rd(1'b1, 32'h5A00012B, "t3_status");
    rd(1'b0, 32'hC3, "t3_rx");
    wr(1'b1, 32'h00000008);
    rd(1'b1, 32'h5A000022, "t3_underrun_clr");

    // Overrun: 17 bytes and no reads. The first 16 are kept and the 17th is lost.
    for (int i = 0; i < 17; i++) m_out[i] = 8'h40 + 8'(i);
    spi_xfer(17 * 8);
    check("t4_fill_b0", {24'b0, m_in[0]}, 32'h5A);
    check("t4_fill_b16", {24'b0, m_in[16]}, 32'h5A);
    rd(1'b1, 32'h5A00102F, "t4_status");
    for (int i = 0; i < 16; i++) rd(1'b0, 32'h40 + 32'(i), $sformatf("t4_rx%0d", i));
    rd(1'b0, 32'h00, "t4_rx17_lost");
    wr(1'b1, 32'h0000000C);
    rd(1'b1, 32'h5A000022, "t4_flags_clr");

    // Aborted frame after 5 rises, then a full frame sending 77.
    wr(1'b0, 32'hC6);
    wr(1'b0, 32'h9B);
    m_out[0] = 8'hF0;
    spi_xfer(5);
    check("t5_abort_bits", {27'b0, m_in[0][7:3]}, 32'h18);
    m_out[0] = 8'h77;
    spi_xfer(8);
    check("t5_next_tx", {24'b0, m_in[0]}, 32'h9B);
    rd(1'b1, 32'h5A000123, "t5_status");
    rd(1'b0, 32'h77, "t5_rx");
    rd(1'b0, 32'h00, "t5_rx_only_one");

    // Tx FIFO full boundary, drop on full, and flush.
    for (int i = 0; i < 16; i++) wr(1'b0, 32'(i));
    rd(1'b1, 32'h5A100000, "tx_full_status");
    wr(1'b0, 32'hEE);
    rd(1'b1, 32'h5A100000, "tx_full_drop");
    wr(1'b1, 32'h00000300);
    rd(1'b1, 32'h5A000022, "tx_flush");

    // Reset mid-frame: the outputs must go low with no clk edge.
    wr(1'b0, 32'hFF);
    wr(1'b0, 32'hFF);
    cs_n = 1'b0;
    wait_clk(5);
    #1;
    check("t6_oe_before", {31'b0, miso_oe}, 32'd1);
    check("t6_miso_before", {31'b0, miso}, 32'd1);
    #5;
    rst_n = 1'b0;
    #1;
    check("t6_oe_async", {31'b0, miso_oe}, 32'd0);
    check("t6_miso_async", {31'b0, miso}, 32'd0);
    cs_n = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    rd(1'b1, 32'hFF000022, "t6_status_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
